// File: rtl/ps2_host_tx.sv
// ps2_host_tx: PS/2 host-to-device command transmitter (request-to-send, odd parity, ACK check)
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int TIMEOUT_CYCLES = 750000
) (
  input  logic       iClk,
  input  logic       iReset_n,
  input  logic       iPs2_Clk,
  input  logic       iPs2_Data,
  input  logic       iStart,
  input  logic [7:0] iData,
  output logic       oBusy,
  output logic       oDone,
  output logic [1:0] oErr,
  output logic       oPs2_Clk_Oe,
  output logic       oPs2_Data_Oe
);
  localparam int IW = $clog2(INHIBIT_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [2:0] {IDLE, INHIBIT, REQ, SEND, ACK, WAIT_IDLE, DONE} state_t;
  state_t state;
  logic [1:0] clkSync, dataSync;
  logic clkPrev;
  logic [9:0] frame;
  logic [3:0] bitCnt;
  logic [IW-1:0] inhCnt;
  logic [TW-1:0] toCnt;
  logic ps2Clk, ps2Data, fe, timeout;
  assign ps2Clk = clkSync[1];
  assign ps2Data = dataSync[1];
  assign fe = clkPrev & ~ps2Clk;
  assign timeout = (toCnt == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge iClk or negedge iReset_n)
    if (!iReset_n) begin
      state <= IDLE;
      clkSync <= 2'b11;
      dataSync <= 2'b11;
      clkPrev <= 1'b1;
      frame <= '0;
      bitCnt <= '0;
      inhCnt <= '0;
      toCnt <= '0;
      oBusy <= 1'b0;
      oDone <= 1'b0;
      oErr <= 2'b00;
      oPs2_Clk_Oe <= 1'b0;
      oPs2_Data_Oe <= 1'b0;
    end else begin
      clkSync <= {clkSync[0], iPs2_Clk};
      dataSync <= {dataSync[0], iPs2_Data};
      clkPrev <= ps2Clk;
      oDone <= 1'b0;
      // saturating watchdog, armed from clock release until completion
      if (state inside {SEND, ACK, WAIT_IDLE} && toCnt != TW'(TIMEOUT_CYCLES))
        toCnt <= toCnt + 1'b1;
      if (timeout && state inside {SEND, ACK, WAIT_IDLE}) begin
        oPs2_Data_Oe <= 1'b0;
        oErr <= 2'b10;
        oDone <= 1'b1;
        state <= DONE;
      end else
        case (state)
          IDLE:
            if (iStart) begin
              frame <= {1'b1, ~^iData, iData};
              bitCnt <= '0;
              inhCnt <= '0;
              oErr <= 2'b00;
              oBusy <= 1'b1;
              oPs2_Clk_Oe <= 1'b1;
              state <= INHIBIT;
            end
          INHIBIT:
            if (inhCnt == IW'(INHIBIT_CYCLES - 1)) begin
              oPs2_Data_Oe <= 1'b1;
              state <= REQ;
            end else
              inhCnt <= inhCnt + 1'b1;
          REQ: begin
            oPs2_Clk_Oe <= 1'b0;
            toCnt <= '0;
            state <= SEND;
          end
          SEND:
            if (fe) begin
              oPs2_Data_Oe <= ~frame[bitCnt];
              bitCnt <= bitCnt + 1'b1;
              if (bitCnt == 4'd9) state <= ACK;
            end
          ACK:
            if (fe) begin
              bitCnt <= bitCnt + 1'b1;
              if (ps2Data) begin
                oErr <= 2'b01;
                oDone <= 1'b1;
                state <= DONE;
              end else
                state <= WAIT_IDLE;
            end
          WAIT_IDLE:
            if (ps2Clk && ps2Data) begin
              oErr <= 2'b00;
              oDone <= 1'b1;
              state <= DONE;
            end
          DONE: begin
            oBusy <= 1'b0;
            state <= IDLE;
          end
          default: state <= IDLE;
        endcase
    end
endmodule

// File: tb/tb_ps2_host_tx.sv
// tb_ps2_host_tx: directed bench for ps2_host_tx with an open-drain PS/2 device model
module tb_ps2_host_tx;
  logic clk = 1'b0, rstN = 1'b0, iStart = 1'b0;
  logic [7:0] iData = '0;
  logic devClkLow = 1'b0, devDataLow = 1'b0;
  logic oBusy, oDone, oPs2_Clk_Oe, oPs2_Data_Oe;
  logic [1:0] oErr;
  logic ps2Clk, ps2Data;
  int checks = 0, errors = 0, cyc = 0, doneCnt = 0, doneCyc = 0, c0 = 0, d0 = 0, w = 0;
  logic [1:0] lastErr = '0;
  logic doneClkOe = 1'b0, doneDataOe = 1'b0, prevDone = 1'b0, busyAfter = 1'b0;
  always #5 clk = ~clk;
  assign ps2Clk = ~(oPs2_Clk_Oe | devClkLow);
  assign ps2Data = ~(oPs2_Data_Oe | devDataLow);
  ps2_host_tx #(.INHIBIT_CYCLES(20), .TIMEOUT_CYCLES(3000)) dut (
    .iClk(clk), .iReset_n(rstN), .iPs2_Clk(ps2Clk), .iPs2_Data(ps2Data),
    .iStart(iStart), .iData(iData), .oBusy(oBusy), .oDone(oDone), .oErr(oErr),
    .oPs2_Clk_Oe(oPs2_Clk_Oe), .oPs2_Data_Oe(oPs2_Data_Oe)
  );
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    if (prevDone) busyAfter = oBusy;
    prevDone = oDone;
    if (oDone) begin
      doneCnt++;
      lastErr = oErr;
      doneClkOe = oPs2_Clk_Oe;
      doneDataOe = oPs2_Data_Oe;
      doneCyc = cyc;
    end
  end
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  // accept a byte and measure how long the clock line is held low
  task automatic startTx(input logic [7:0] d, input logic midStart, output int sendCyc);
    int n = 0;
    logic lastData = 1'b0;
    iStart = 1'b1;
    iData = d;
    step(1);
    iStart = 1'b0;
    iData = 8'h55;
    check("busyRise", oBusy, 1);
    check("clkOeRise", oPs2_Clk_Oe, 1);
    check("inhibitDataOe", oPs2_Data_Oe, 0);
    while (oPs2_Clk_Oe && n < 100) begin
      iStart = midStart && n == 5;
      if (midStart && n == 5) iData = 8'hAA;
      lastData = oPs2_Data_Oe;
      n++;
      step(1);
    end
    iStart = 1'b0;
    check("clkLowCycles", n, 21);
    check("reqDataOe", lastData, 1);
    sendCyc = cyc;
  endtask
  task automatic runFrame(input logic [9:0] expFrame, input logic ack, input int lastEdge);
    logic [9:0] rx = '0;
    for (int k = 1; k <= lastEdge; k++) begin
      devClkLow = 1'b0;
      if (k == 11) devDataLow = ack;
      step(50);
      devClkLow = 1'b1;
      step(25);
      if (k <= 10) rx[k-1] = ps2Data;
      if (k < lastEdge) step(25);
    end
    if (lastEdge == 11) begin
      check("frame", rx, expFrame);
      devClkLow = 1'b0;
      devDataLow = 1'b0;
    end
  endtask
  task automatic finishTx(input int base, input logic [1:0] expErr);
    step(10);
    check("doneCount", doneCnt, base + 1);
    check("doneErr", lastErr, expErr);
    check("doneClkOe", doneClkOe, 0);
    check("doneDataOe", doneDataOe, 0);
    check("busyAfterDone", busyAfter, 0);
  endtask
  initial begin
    step(3);
    check("rstBusy", oBusy, 0);
    check("rstDone", oDone, 0);
    check("rstErr", oErr, 0);
    check("rstClkOe", oPs2_Clk_Oe, 0);
    check("rstDataOe", oPs2_Data_Oe, 0);
    rstN = 1'b1;
    step(3);
    // 0xED acknowledged: pad bits 1,0,1,1,0,1,1,1, parity 1, stop 1
    d0 = doneCnt;
    startTx(8'hED, 1'b0, c0);
    runFrame(10'h3ED, 1'b1, 11);
    finishTx(d0, 2'b00);
    // 0x00 needs parity 1, 0x01 needs parity 0; second one also gets a stray iStart
    d0 = doneCnt;
    startTx(8'h00, 1'b0, c0);
    runFrame(10'h300, 1'b1, 11);
    finishTx(d0, 2'b00);
    d0 = doneCnt;
    startTx(8'h01, 1'b1, c0);
    runFrame(10'h201, 1'b1, 11);
    finishTx(d0, 2'b00);
    // device leaves data high at ACK
    d0 = doneCnt;
    startTx(8'hED, 1'b0, c0);
    runFrame(10'h3ED, 1'b0, 11);
    finishTx(d0, 2'b01);
    // device never clocks
    d0 = doneCnt;
    startTx(8'hFF, 1'b0, c0);
    w = 0;
    while (doneCnt == d0 && w < 4000) begin
      step(1);
      w++;
    end
    step(2);
    check("toDoneCount", doneCnt, d0 + 1);
    check("toLatency", doneCyc - c0, 3000);
    check("toErr", lastErr, 2'b10);
    check("toClkOe", doneClkOe, 0);
    check("toDataOe", doneDataOe, 0);
    check("toBusyAfter", busyAfter, 0);
    // asynchronous reset while bit 4 is on the line
    d0 = doneCnt;
    startTx(8'h00, 1'b0, c0);
    runFrame(10'h300, 1'b1, 4);
    check("preRstDataOe", oPs2_Data_Oe, 1);
    #2 rstN = 1'b0;
    #1;
    check("asyncRstBusy", oBusy, 0);
    check("asyncRstClkOe", oPs2_Clk_Oe, 0);
    check("asyncRstDataOe", oPs2_Data_Oe, 0);
    @(negedge clk);
    rstN = 1'b1;
    devClkLow = 1'b0;
    step(5);
    check("rstNoDone", doneCnt, d0);
    d0 = doneCnt;
    startTx(8'hFF, 1'b0, c0);
    runFrame(10'h3FF, 1'b1, 11);
    finishTx(d0, 2'b00);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
